// File: rtl/pipe_pkg.sv
// Shared pipeline-latch constants: exception bit positions and the default latched-exception mask.
// Pure definitions: no latency, no backpressure.
package pipe_pkg;

    localparam int EXC_W_DEF = 32;

    localparam int EXC_LD_MISALIGN = 4;
    localparam int EXC_ST_MISALIGN = 6;
    localparam int EXC_LD_FAULT    = 13;
    localparam int EXC_ST_FAULT    = 15;

    localparam logic [EXC_W_DEF-1:0] PIPE_EXC_MASK =
        (EXC_W_DEF'(1) << EXC_LD_MISALIGN) |
        (EXC_W_DEF'(1) << EXC_ST_MISALIGN) |
        (EXC_W_DEF'(1) << EXC_LD_FAULT)    |
        (EXC_W_DEF'(1) << EXC_ST_FAULT);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, payload, exception); clear beats load, cleared slots read as all-zero.
// Latency: loaded value visible the cycle after ld_i; no backpressure of its own.
module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int EXC_W  = 32
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [EXC_W-1:0]  exc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [EXC_W-1:0]  exc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [EXC_W-1:0]  exc_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            exc_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            exc_q   <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            exc_q   <= exc_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage latch with valid/ready, kill and optional skid slot; 1-cycle latency, full throughput.
// SKID=1 gives a registered in_ready_o (deasserts only when the skid slot is occupied); SKID=0 is combinational.
module pipe_skid_latch
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                EXC_W    = EXC_W_DEF,
    parameter logic [EXC_W-1:0]  EXC_MASK = EXC_W'(PIPE_EXC_MASK),
    parameter bit                SKID     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              kill_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [EXC_W-1:0]  in_exc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [EXC_W-1:0]  out_exc_o,
    output logic              out_exc_any_o,
    output logic [1:0]        occ_o
);

    logic              main_vld, skid_vld;
    logic [DATA_W-1:0] main_dat, skid_dat, main_din;
    logic [EXC_W-1:0]  main_exc, skid_exc, main_ein, in_exc_m;
    logic              main_ld, main_clr, skid_ld, skid_clr, main_from_skid;
    logic              accept, pop;

    assign in_exc_m = in_exc_i & EXC_MASK;
    assign pop      = main_vld & out_ready_i;
    assign accept   = in_valid_i & in_ready_o;

    always_comb begin
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (kill_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (pop && skid_vld) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
        end else if (accept && (!main_vld || pop)) begin
            main_ld = 1'b1;
        end else if (accept) begin
            // Main is held by a stalled consumer, so the new entry parks in skid.
            skid_ld = 1'b1;
        end else if (pop) begin
            main_clr = 1'b1;
        end
    end

    assign main_din = main_from_skid ? skid_dat : in_data_i;
    assign main_ein = main_from_skid ? skid_exc : in_exc_m;

    pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .data_i  (main_din),
        .exc_i   (main_ein),
        .valid_o (main_vld),
        .data_o  (main_dat),
        .exc_o   (main_exc)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
                .clk_i   (clk_i),
                .rsn_i   (rsn_i),
                .clr_i   (skid_clr),
                .ld_i    (skid_ld),
                .data_i  (in_data_i),
                .exc_i   (in_exc_m),
                .valid_o (skid_vld),
                .data_o  (skid_dat),
                .exc_o   (skid_exc)
            );
            assign in_ready_o = !skid_vld;
        end else begin : g_noskid
            assign skid_vld   = 1'b0;
            assign skid_dat   = '0;
            assign skid_exc   = '0;
            assign in_ready_o = !main_vld | out_ready_i;
        end
    endgenerate

    assign out_valid_o   = main_vld;
    assign out_data_o    = main_dat;
    assign out_exc_o     = main_exc;
    assign out_exc_any_o = main_vld & (|main_exc);
    assign occ_o         = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: SKID=1 and SKID=0 instances share stimulus, each checked every cycle
// against a queue-based reference model (FIFO of capacity 2 or 1, kill empties it).
module tb_pipe_skid_latch;

    typedef struct {
        logic [127:0] d;
        logic [31:0]  e;
    } ent_t;

    localparam logic [31:0] MASK = 32'h0000_A050;

    logic         clk = 1'b0;
    logic         rsn;
    logic         kill;
    logic         in_valid;
    logic [127:0] in_data;
    logic [31:0]  in_exc;
    logic         out_ready;

    logic         rdy1, vld1, any1;
    logic [127:0] dat1;
    logic [31:0]  exc1;
    logic [1:0]   occ1;

    logic         rdy0, vld0, any0;
    logic [31:0]  dat0;
    logic [31:0]  exc0;
    logic [1:0]   occ0;

    ent_t q1[$];
    ent_t q0[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_latch #(.DATA_W(128), .SKID(1'b1)) dut1 (
        .clk_i         (clk),
        .rsn_i         (rsn),
        .kill_i        (kill),
        .in_valid_i    (in_valid),
        .in_ready_o    (rdy1),
        .in_data_i     (in_data),
        .in_exc_i      (in_exc),
        .out_valid_o   (vld1),
        .out_ready_i   (out_ready),
        .out_data_o    (dat1),
        .out_exc_o     (exc1),
        .out_exc_any_o (any1),
        .occ_o         (occ1)
    );

    pipe_skid_latch #(.DATA_W(32), .SKID(1'b0)) dut0 (
        .clk_i         (clk),
        .rsn_i         (rsn),
        .kill_i        (kill),
        .in_valid_i    (in_valid),
        .in_ready_o    (rdy0),
        .in_data_i     (in_data[31:0]),
        .in_exc_i      (in_exc),
        .out_valid_o   (vld0),
        .out_ready_i   (out_ready),
        .out_data_o    (dat0),
        .out_exc_o     (exc0),
        .out_exc_any_o (any0),
        .occ_o         (occ0)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares both DUTs against their model queues as they stand before the next edge.
    task automatic check_outputs();
        ent_t h1, h0;
        h1.d = '0; h1.e = '0;
        h0.d = '0; h0.e = '0;
        if (q1.size() > 0) h1 = q1[0];
        if (q0.size() > 0) h0 = q0[0];
        check_val("s1_in_ready", 128'(rdy1), 128'(q1.size() < 2));
        check_val("s1_out_valid", 128'(vld1), 128'(q1.size() > 0));
        check_val("s1_out_data", dat1, h1.d);
        check_val("s1_out_exc", 128'(exc1), 128'(h1.e));
        check_val("s1_exc_any", 128'(any1), 128'(q1.size() > 0 && h1.e != 0));
        check_val("s1_occ", 128'(occ1), 128'(q1.size()));
        check_val("s0_in_ready", 128'(rdy0), 128'(q0.size() == 0 || out_ready));
        check_val("s0_out_valid", 128'(vld0), 128'(q0.size() > 0));
        check_val("s0_out_data", 128'(dat0), 128'(h0.d[31:0]));
        check_val("s0_out_exc", 128'(exc0), 128'(h0.e));
        check_val("s0_exc_any", 128'(any0), 128'(q0.size() > 0 && h0.e != 0));
        check_val("s0_occ", 128'(occ0), 128'(q0.size()));
    endtask

    // Inputs are already driven (just after a falling edge); check, clock once, update the models.
    task automatic cycle();
        bit   acc1, pop1, acc0, pop0;
        ent_t e;
        #1;
        check_outputs();
        acc1 = in_valid && (q1.size() < 2);
        pop1 = (q1.size() > 0) && out_ready;
        acc0 = in_valid && (q0.size() == 0 || out_ready);
        pop0 = (q0.size() > 0) && out_ready;
        e.d  = in_data;
        e.e  = in_exc & MASK;
        @(posedge clk);
        if (kill) begin
            q1.delete();
            q0.delete();
        end else begin
            if (pop1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (pop0) void'(q0.pop_front());
            if (acc0) begin
                e.d = {96'h0, in_data[31:0]};
                q0.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [127:0] d, input logic [31:0] x, input bit ordy, input bit k);
        in_valid  = v;
        in_data   = d;
        in_exc    = x;
        out_ready = ordy;
        kill      = k;
    endtask

    initial begin
        rsn = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rsn = 1'b1;

        // Back-to-back stream with a free consumer.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 128'(i), 32'h0, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Stall fill: A and B land, C waits, then everything drains in order.
        drive(1'b1, 128'hA, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 128'hB, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 128'hC, 32'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        drive(1'b1, 128'hC, 32'h0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle();

        // Kill racing an offered entry while full.
        drive(1'b1, 128'h11, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 128'h22, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 128'hD, 32'h0, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Exception masking.
        drive(1'b1, 128'h55, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 128'h66, 32'h0000_0001, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Asynchronous reset while full.
        drive(1'b1, 128'h77, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 128'h88, 32'h0, 1'b0, 1'b0);
        cycle();
        #2;
        rsn = 1'b0;
        q1.delete();
        q0.delete();
        #1;
        check_outputs();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rsn = 1'b1;
        cycle();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
